// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the EX-stage controller and alu_mc.
//   EX        start strobe (accepted only while busy=0)
//   I         5-bit opcode
//   op1/op2   W-bit operands
//   res1      W-bit registered result
//   carry/z   registered carry/overflow and zero flags
//   busy      iterative op in progress
//   done      one-cycle pulse when a new result becomes visible
interface alu_mc_if #(
    parameter int W = 32
);
    logic         EX;
    logic [4:0]   I;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [W-1:0] res1;
    logic         carry;
    logic         z;
    logic         busy;
    logic         done;

    modport master (
        output EX, I, op1, op2,
        input  res1, carry, z, busy, done
    );

    modport slave (
        input  EX, I, op1, op2,
        output res1, carry, z, busy, done
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
//   Opcodes 0-15 complete in one cycle from the live operands; 16-19 are
//   iterative unsigned MULLO/MULHI/DIVU/REMU taking W cycles on operands
//   latched at acceptance; 20-31 return zero.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_mc_if slave (EX/I/op1/op2 in, res1/carry/z/busy/done out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for EX; single-cycle ops complete here
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
module alu_mc #(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hi_sel_q, hi_sel_d;     // MULHI / REMU select
    logic [2*W-1:0] acc_q, acc_d;           // product; low half doubles as dividend/quotient
    logic [W-1:0]   mcand_q, mcand_d;       // multiplicand or divisor
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   res1_q, res1_d;
    logic           carry_q, carry_d;
    logic           z_q, z_d;
    logic           done_q, done_d;

    logic [W:0]     add_full, sub_full;
    logic [W-1:0]   sc_res;
    logic           sc_carry;
    logic [SHW-1:0] sh;
    logic           is_iter;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift, div_diff;
    logic           div_ge;
    logic [W-1:0]   div_rem_next, div_quo_next;
    logic           div_unused;
    logic [W-1:0]   fin_res;

    assign sh       = bus.op2[SHW-1:0];
    assign add_full = {1'b0, bus.op1} + {1'b0, bus.op2};
    assign sub_full = {1'b0, bus.op1} - {1'b0, bus.op2};
    assign is_iter  = (bus.I[4:2] == 3'b100);

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        case (bus.I)
            5'd0:  sc_res = bus.op2 << 16;
            5'd1:  {sc_carry, sc_res} = add_full;
            5'd2:  {sc_carry, sc_res} = sub_full;
            5'd3:  sc_res = bus.op1 & bus.op2;
            5'd4:  sc_res = bus.op1 | bus.op2;
            5'd5:  sc_res = bus.op1 ^ bus.op2;
            5'd6:  sc_res = bus.op1 << sh;
            5'd7:  sc_res = bus.op1 >> sh;
            5'd8:  sc_res = (bus.op1 == '0) ? bus.op2 : '0;
            5'd9:  sc_res = (bus.op1 != '0) ? bus.op2 : '0;
            5'd10: sc_res = (bus.op1 == bus.op2) ? '1 : '0;
            5'd11: sc_res = (bus.op1 <= bus.op2) ? '1 : '0;
            5'd12: sc_res = (bus.op1 <  bus.op2) ? '1 : '0;
            5'd13: sc_res = (bus.op1 != bus.op2) ? '1 : '0;
            5'd14: sc_res = $unsigned($signed(bus.op1) >>> sh);
            5'd15: sc_res = bus.op1 + W'(4);
            default: sc_res = '0;
        endcase
    end

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: bring the next dividend bit into the partial remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and the dividend as remainder.
    assign div_shift    = {rem_q, acc_q[W-1]};
    assign div_ge       = (div_shift >= {1'b0, mcand_q});
    assign div_diff     = div_shift - {1'b0, mcand_q};
    assign div_rem_next = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
    assign div_quo_next = {acc_q[W-2:0], div_ge};
    assign div_unused   = div_diff[W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_sel_d = hi_sel_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        res1_d   = res1_q;
        carry_d  = carry_q;
        z_d      = z_q;
        done_d   = 1'b0;
        fin_res  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.EX) begin
                    if (is_iter) begin
                        acc_d    = {{W{1'b0}}, bus.op1};
                        mcand_d  = bus.op2;
                        rem_d    = '0;
                        hi_sel_d = bus.I[0];
                        cnt_d    = CW'(W);
                        state_d  = bus.I[1] ? S_DIV : S_MUL;
                    end else begin
                        res1_d  = sc_res;
                        carry_d = sc_carry;
                        z_d     = (sc_res == '0);
                        done_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin_res = hi_sel_q ? mul_next[2*W-1:W] : mul_next[W-1:0];
                    res1_d  = fin_res;
                    carry_d = ~hi_sel_q & (|mul_next[2*W-1:W]);
                    z_d     = (fin_res == '0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = {acc_q[2*W-1:W], div_quo_next};
                rem_d = div_rem_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin_res = hi_sel_q ? div_rem_next : div_quo_next;
                    res1_d  = fin_res;
                    carry_d = 1'b0;
                    z_d     = (fin_res == '0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            res1_q   <= '0;
            carry_q  <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_sel_q <= hi_sel_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            res1_q   <= res1_d;
            carry_q  <= carry_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign bus.res1  = res1_q;
    assign bus.carry = carry_q;
    assign bus.z     = z_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at W=32 and W=16.
module tb_alu_mc;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.W(32)) bus32 ();
    alu_mc_if #(.W(16)) bus16 ();

    alu_mc #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_mc #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        zf;
    } vec_t;

    vec_t sc_tab [22];
    vec_t it_tab [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus32.EX = 1'b0; bus32.I = '0; bus32.op1 = '0; bus32.op2 = '0;
        bus16.EX = 1'b0; bus16.I = '0; bus16.op1 = '0; bus16.op2 = '0;
        rst_n = 1'b0;
        #3;
        tests_run++;
        if ({bus32.res1, bus32.carry, bus32.z, bus32.busy, bus32.done} !== '0) begin
            tests_failed++;
            $display("FAIL reset32 res1=%h c=%b z=%b busy=%b done=%b expected all zero",
                     bus32.res1, bus32.carry, bus32.z, bus32.busy, bus32.done);
        end
        tests_run++;
        if ({bus16.res1, bus16.carry, bus16.z, bus16.busy, bus16.done} !== '0) begin
            tests_failed++;
            $display("FAIL reset16 res1=%h c=%b z=%b busy=%b done=%b expected all zero",
                     bus16.res1, bus16.carry, bus16.z, bus16.busy, bus16.done);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        sc_tab[0]  = '{5'd1,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b1, 1'b1};
        sc_tab[1]  = '{5'd2,  32'd3,         32'd5,        32'hFFFF_FFFE, 1'b1, 1'b0};
        sc_tab[2]  = '{5'd14, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1'b0, 1'b0};
        sc_tab[3]  = '{5'd11, 32'd5,         32'd5,        32'hFFFF_FFFF, 1'b0, 1'b0};
        sc_tab[4]  = '{5'd0,  32'h0000_DEAD, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0};
        sc_tab[5]  = '{5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        sc_tab[6]  = '{5'd4,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0};
        sc_tab[7]  = '{5'd5,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0};
        sc_tab[8]  = '{5'd6,  32'd1,         32'd31,       32'h8000_0000, 1'b0, 1'b0};
        sc_tab[9]  = '{5'd7,  32'h8000_0000, 32'd31,       32'h0000_0001, 1'b0, 1'b0};
        sc_tab[10] = '{5'd6,  32'd1,         32'd32,       32'h0000_0001, 1'b0, 1'b0};
        sc_tab[11] = '{5'd8,  32'd0,         32'd77,       32'd77,        1'b0, 1'b0};
        sc_tab[12] = '{5'd9,  32'd0,         32'd77,       32'd0,         1'b0, 1'b1};
        sc_tab[13] = '{5'd9,  32'd3,         32'd77,       32'd77,        1'b0, 1'b0};
        sc_tab[14] = '{5'd10, 32'd7,         32'd7,        32'hFFFF_FFFF, 1'b0, 1'b0};
        sc_tab[15] = '{5'd12, 32'd5,         32'd5,        32'd0,         1'b0, 1'b1};
        sc_tab[16] = '{5'd12, 32'd4,         32'd5,        32'hFFFF_FFFF, 1'b0, 1'b0};
        sc_tab[17] = '{5'd13, 32'd4,         32'd5,        32'hFFFF_FFFF, 1'b0, 1'b0};
        sc_tab[18] = '{5'd15, 32'hFFFF_FFFE, 32'd0,        32'd2,         1'b0, 1'b0};
        sc_tab[19] = '{5'd1,  32'd2,         32'd3,        32'd5,         1'b0, 1'b0};
        sc_tab[20] = '{5'd2,  32'd5,         32'd3,        32'd2,         1'b0, 1'b0};
        sc_tab[21] = '{5'd14, 32'h4000_0000, 32'd4,        32'h0400_0000, 1'b0, 1'b0};
        // EX stays high across the table: one result per cycle, done held high.
        for (int i = 0; i < 22; i++) begin
            bus32.EX = 1'b1; bus32.I = sc_tab[i].op;
            bus32.op1 = sc_tab[i].a; bus32.op2 = sc_tab[i].b;
            tick();
            tests_run++;
            if ({bus32.res1, bus32.carry, bus32.z, bus32.done} !==
                {sc_tab[i].r, sc_tab[i].c, sc_tab[i].zf, 1'b1}) begin
                tests_failed++;
                $display("FAIL sc[%0d] op=%0d res1=%h c=%b z=%b done=%b expected res1=%h c=%b z=%b done=1",
                         i, sc_tab[i].op, bus32.res1, bus32.carry, bus32.z, bus32.done,
                         sc_tab[i].r, sc_tab[i].c, sc_tab[i].zf);
            end
        end
        bus32.EX = 1'b0;
        bus32.op1 = 32'h1111_1111;
        tick();
        tests_run++;
        if ({bus32.done, bus32.busy, bus32.res1} !== {1'b0, 1'b0, 32'h0400_0000}) begin
            tests_failed++;
            $display("FAIL sc_idle_hold done=%b busy=%b res1=%h expected done=0 busy=0 res1=04000000",
                     bus32.done, bus32.busy, bus32.res1);
        end
    endtask

    task automatic test_iterative();
        int cycles;
        int early;
        it_tab[0]  = '{5'd16, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1};
        it_tab[1]  = '{5'd17, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0};
        it_tab[2]  = '{5'd16, 32'd3,         32'd5,         32'd15,        1'b0, 1'b0};
        it_tab[3]  = '{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
        it_tab[4]  = '{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
        it_tab[5]  = '{5'd18, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0};
        it_tab[6]  = '{5'd19, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0};
        it_tab[7]  = '{5'd18, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
        it_tab[8]  = '{5'd19, 32'd5,         32'd0,         32'd5,         1'b0, 1'b0};
        it_tab[9]  = '{5'd18, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0};
        it_tab[10] = '{5'd19, 32'd7,         32'd100,       32'd7,         1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus32.EX = 1'b1; bus32.I = it_tab[i].op;
            bus32.op1 = it_tab[i].a; bus32.op2 = it_tab[i].b;
            tick();
            // Operands must have been latched: scramble the live inputs.
            bus32.EX = 1'b0; bus32.I = 5'd1;
            bus32.op1 = ~it_tab[i].a; bus32.op2 = ~it_tab[i].b;
            tests_run++;
            if ({bus32.busy, bus32.done} !== 2'b10) begin
                tests_failed++;
                $display("FAIL it[%0d] start busy=%b done=%b expected busy=1 done=0",
                         i, bus32.busy, bus32.done);
            end
            cycles = 0;
            early  = 0;
            while (bus32.busy === 1'b1 && cycles < 100) begin
                if (bus32.done === 1'b1) early++;
                tick();
                cycles++;
            end
            tests_run++;
            if (cycles != 32 || early != 0) begin
                tests_failed++;
                $display("FAIL it[%0d] latency cycles=%0d early_done=%0d expected cycles=32 early_done=0",
                         i, cycles, early);
            end
            tests_run++;
            if ({bus32.res1, bus32.carry, bus32.z, bus32.done} !==
                {it_tab[i].r, it_tab[i].c, it_tab[i].zf, 1'b1}) begin
                tests_failed++;
                $display("FAIL it[%0d] op=%0d res1=%h c=%b z=%b done=%b expected res1=%h c=%b z=%b done=1",
                         i, it_tab[i].op, bus32.res1, bus32.carry, bus32.z, bus32.done,
                         it_tab[i].r, it_tab[i].c, it_tab[i].zf);
            end
            tick();
            tests_run++;
            if ({bus32.done, bus32.res1} !== {1'b0, it_tab[i].r}) begin
                tests_failed++;
                $display("FAIL it[%0d] after done=%b res1=%h expected done=0 res1=%h",
                         i, bus32.done, bus32.res1, it_tab[i].r);
            end
        end
    endtask

    task automatic test_ex_while_busy();
        int cyc = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        bus32.EX = 1'b1; bus32.I = 5'd18; bus32.op1 = 32'd100; bus32.op2 = 32'd7;
        tick();
        bus32.EX = 1'b0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (bus32.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == 3) begin
                bus32.EX = 1'b1; bus32.I = 5'd1; bus32.op1 = 32'd1; bus32.op2 = 32'd1;
            end else if (cyc == 4) begin
                bus32.EX = 1'b0;
            end
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != 32) begin
            tests_failed++;
            $display("FAIL busy_ignore done_count=%0d done_cycle=%0d expected done_count=1 done_cycle=32",
                     done_cnt, done_cyc);
        end
        tests_run++;
        if ({bus32.res1, bus32.carry, bus32.z} !== {32'd14, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL busy_ignore_result res1=%h c=%b z=%b expected res1=0000000e c=0 z=0",
                     bus32.res1, bus32.carry, bus32.z);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        bus32.EX = 1'b1; bus32.I = 5'd16; bus32.op1 = 32'h0001_0000; bus32.op2 = 32'h0001_0000;
        tick();
        bus32.EX = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (bus32.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_busy busy=%b expected 1", bus32.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus32.res1, bus32.carry, bus32.z, bus32.busy, bus32.done} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async res1=%h c=%b z=%b busy=%b done=%b expected all zero",
                     bus32.res1, bus32.carry, bus32.z, bus32.busy, bus32.done);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus32.done === 1'b1 || bus32.busy === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0 || bus32.res1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_done activity=%0d res1=%h expected activity=0 res1=00000000",
                     dones, bus32.res1);
        end
        bus32.EX = 1'b1; bus32.I = 5'd1; bus32.op1 = 32'd2; bus32.op2 = 32'd2;
        tick();
        bus32.EX = 1'b0;
        tests_run++;
        if ({bus32.res1, bus32.carry, bus32.z, bus32.done} !== {32'd4, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_mid_add res1=%h c=%b z=%b done=%b expected res1=00000004 c=0 z=0 done=1",
                     bus32.res1, bus32.carry, bus32.z, bus32.done);
        end
    endtask

    task automatic test_reserved();
        logic [4:0] rops [3];
        rops[0] = 5'd25; rops[1] = 5'd20; rops[2] = 5'd31;
        for (int i = 0; i < 3; i++) begin
            // Make res1 nonzero first so the reserved op visibly clears it.
            bus32.EX = 1'b1; bus32.I = 5'd1; bus32.op1 = 32'd9; bus32.op2 = 32'd9;
            tick();
            bus32.I = rops[i]; bus32.op1 = 32'hFFFF_FFFF; bus32.op2 = 32'hFFFF_FFFF;
            tick();
            bus32.EX = 1'b0;
            tests_run++;
            if ({bus32.res1, bus32.carry, bus32.z, bus32.done, bus32.busy} !==
                {32'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL reserved op=%0d res1=%h c=%b z=%b done=%b busy=%b expected res1=0 c=0 z=1 done=1 busy=0",
                         rops[i], bus32.res1, bus32.carry, bus32.z, bus32.done, bus32.busy);
            end
            tick();
            tests_run++;
            if (bus32.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reserved_pulse op=%0d done=%b expected 0", rops[i], bus32.done);
            end
        end
    endtask

    task automatic test_w16();
        logic [4:0]  ops [3];
        logic [15:0] as [3];
        logic [15:0] bs [3];
        logic [15:0] rs [3];
        logic        cs [3];
        int cycles;
        ops[0] = 5'd17; as[0] = 16'hFFFF; bs[0] = 16'hFFFF; rs[0] = 16'hFFFE; cs[0] = 1'b0;
        ops[1] = 5'd16; as[1] = 16'hFFFF; bs[1] = 16'hFFFF; rs[1] = 16'h0001; cs[1] = 1'b1;
        ops[2] = 5'd18; as[2] = 16'hFFFF; bs[2] = 16'h0000; rs[2] = 16'hFFFF; cs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus16.EX = 1'b1; bus16.I = ops[i]; bus16.op1 = as[i]; bus16.op2 = bs[i];
            tick();
            bus16.EX = 1'b0;
            cycles = 0;
            while (bus16.busy === 1'b1 && cycles < 60) begin
                tick();
                cycles++;
            end
            tests_run++;
            if (cycles != 16) begin
                tests_failed++;
                $display("FAIL w16[%0d] latency cycles=%0d expected 16", i, cycles);
            end
            tests_run++;
            if ({bus16.res1, bus16.carry, bus16.done} !== {rs[i], cs[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL w16[%0d] op=%0d res1=%h c=%b done=%b expected res1=%h c=%b done=1",
                         i, ops[i], bus16.res1, bus16.carry, bus16.done, rs[i], cs[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_iterative();
        test_ex_while_busy();
        test_reset_mid();
        test_reserved();
        test_w16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the single-cycle execute-stage ALU. It keeps the single-cycle operation set (now width-generic, with full-range shifts) and adds iterative unsigned multiply and divide/remainder behind a start/busy/done handshake. It sits in the EX stage. The pipeline controller stalls on `busy` and consumes `res1`/`carry`/`z` when `done` pulses.

## Interface
Parameters:
- `W`, 32: datapath width; minimum 8, power of two.
- `SHW`, $clog2(W): shift-amount width. Shifts use `op2[SHW-1:0]`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `EX`  in  1  start strobe; accepted only when `busy`=0.
- `I`  in  5  opcode, sampled with `EX`.
- `op1`  in  W  first operand, sampled with `EX`.
- `op2`  in  W  second operand, sampled with `EX`.
- `res1`  out  W  registered result; holds until the next accepted op completes.
- `carry`  out  1  registered carry/overflow flag.
- `z`  out  1  registered zero flag; equals (`res1`==0) for the written result.
- `busy`  out  1  high while an iterative op is in progress.
- `done`  out  1  one-cycle pulse in the cycle the new `res1`/flags become visible.

## Operation
Opcodes 0-15 are single-cycle and computed combinationally from the live `op1`/`op2`:
- 0: `op2<<16`.
- 1: ADD. `{carry,res}`=`op1+op2`.
- 2: SUB. `{carry,res}`=`op1-op2`; carry is the borrow.
- 3: AND. 4: OR. 5: XOR.
- 6: SLL. 7: SRL (logical). 14: SRA (arithmetic, `op1` treated as signed).
- 8: `op1==0 ? op2 : 0`. 9: `op1!=0 ? op2 : 0`.
- 10: SEQ. 11: SLE (unsigned). 12: SLT (unsigned). 13: SNE. Each produces all-ones when true, else 0.
- 15: `op1+4`.
- Carry is 0 for every single-cycle op except 1 and 2.

Opcodes 16-19 are iterative (all unsigned), computed on operands latched at acceptance:
- 16: MULLO. Low W bits of `op1*op2`; carry=1 if the high W bits are nonzero.
- 17: MULHI. High W bits of `op1*op2`; carry=0.
- 18: DIVU. Quotient; carry=0.
- 19: REMU. Remainder; carry=0.
- Implementation: radix-2 shift-add multiplier (2W-bit accumulator) and restoring divider (W+1-bit partial remainder), one bit per cycle.
- Divide by zero is not special-cased in the datapath and needs no extra logic: it yields quotient all-ones and remainder=`op1`. Carry=0 and the latency is unchanged.

Opcodes 20-31 are reserved: single-cycle, res1=0, carry=0, z=1.

State machine (IDLE, MUL, DIV) with iteration counter `cnt` of width $clog2(W+1):
- IDLE, `EX`=1, single-cycle op: write the results, pulse `done`, stay in IDLE.
- IDLE, `EX`=1, op 16/17: latch operands and the op, set `cnt`=W, go to MUL.
- IDLE, `EX`=1, op 18/19: latch operands and the op, set `cnt`=W, go to DIV.
- MUL/DIV: one iteration per cycle, decrementing `cnt`. On the iteration that reaches 0, write `res1`/`carry`/`z`, pulse `done`, return to IDLE.
- `EX` while `busy`=1 is ignored. It is not queued, and `I`/`op1`/`op2` changes have no effect.

Reset (`rst_n`=0, asynchronous):
- res1=0, carry=0, z=0, busy=0, done=0, state=IDLE.
- Reset mid-iteration abandons the op and produces no `done`.

## Timing
- Single-cycle op accepted at edge E: `res1`/flags are valid and `done`=1 after E; `done` drops after E+1 unless another op is accepted at E+1.
- Back-to-back single-cycle ops give one result per cycle with `done` held high.
- Iterative op accepted at edge E:
  - `busy`=1 after E through edge E+W-1.
  - After E+W: `busy`=0, `done`=1, result valid.
  - Latency is W cycles, independent of operand values.
- A new op can be accepted at edge E+W+0 only if `EX` is sampled while `busy`=0, i.e. the earliest acceptance is the edge after `done` rises (E+W+1).
- Outputs change only on accepted or completed ops. `res1` holds otherwise.

## Test plan
- Reset, then single-cycle ops: ADD 0xFFFFFFFF+1 -> res1=0, carry=1, z=1, `done` one cycle later. SUB 3-5 -> 0xFFFFFFFE, carry=1. SRA 0x80000000 by 31 -> 0xFFFFFFFF (verifies full shift range). SLE 5,5 -> 0xFFFFFFFF.
- MULLO 0x10000*0x10000 -> res1=0, carry=1, z=1. MULHI of the same operands -> res1=1. `busy` high exactly 32 cycles, `done` at the 32nd edge after acceptance.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Latency 32 in every case.
- `EX` pulsed with ADD while a DIVU is busy -> ignored. DIVU result unchanged, exactly one `done`, ADD never executed.
- `rst_n` asserted at iteration 10 of MULLO -> outputs 0 immediately with no clock. After release, no `done` appears and the next ADD 2+2 -> 4.
- Reserved opcode 25 -> res1=0, z=1, carry=0, `done` pulse. Repeat with W=16: MULHI 0xFFFF*0xFFFF -> 0xFFFE after 16 cycles.
